// File: rtl/stream_checker_pkg.sv
// stream_checker_pkg
//   Shared definitions for the stream checker slice.
//   - FSM state encodings (2-bit, encoding 3 unused)
//   - default parameter values for DATA_W / CNT_W / TIMEOUT
//   - sat_inc(): saturating increment for counters up to 32 bits wide
package stream_checker_pkg;

    localparam logic [1:0] ST_WAIT_FIRST = 2'd0;
    localparam logic [1:0] ST_TRACK      = 2'd1;
    localparam logic [1:0] ST_FAILED     = 2'd2;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 16;

    // Increment v, holding at the all-ones value of a w-bit counter.
    // Works on a 32-bit carrier so one function serves any counter width <= 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_checker_if.sv
// stream_checker_if
//   Beat link between the data sender and the checker.
//   en   : beat qualifier, data valid when high
//   data : payload word, DATA_W bits
//   modports: master (sender drives en/data), slave (checker samples en/data)
interface stream_checker_if
    import stream_checker_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              en;
    logic [DATA_W-1:0] data;

    modport master (output en, output data);
    modport slave  (input  en, input  data);
endinterface

// File: rtl/gap_watchdog.sv
// gap_watchdog
//   Counts consecutive idle cycles while armed and flags the edge on which the
//   count reaches TIMEOUT. The count then holds at TIMEOUT, so expired pulses
//   exactly once per stall.
//   clk     : clock
//   rst     : synchronous active-high reset
//   arm     : counting enabled (checker has a reference word)
//   kick    : beat present this cycle, clears the count
//   expired : high in the cycle whose edge moves the count to TIMEOUT
module gap_watchdog #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic kick,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] gap;

    // Look one cycle ahead so the caller's sticky flag lands on the same edge
    // as the counter reaching TIMEOUT.
    assign expired = arm && !kick && (gap == LIMIT_M1);

    always_ff @(posedge clk) begin
        if (rst || !arm || kick) begin
            gap <= '0;
        end else if (gap != LIMIT) begin
            gap <= gap + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stream_checker.sv
// stream_checker
//   Consumer on the en/data link. Checks that successive beats increment by one
//   modulo 2^DATA_W, counts accepted beats and sequence errors (saturating) and
//   raises a sticky failure flag on the first break.
//   Optional watchdog: define STREAM_CHECKER_TIMEOUT_EN to build the idle-gap
//   counter; TIMEOUT idle cycles after the first word then set timeout and
//   failure. Without the macro timeout is tied low and TIMEOUT is ignored.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     link         : stream_checker_if.slave (en, data)
//     failure      : sticky error flag
//     timeout      : sticky watchdog flag
//     word_count   : beats accepted since reset, saturating
//     error_count  : sequence mismatches since reset, saturating
//     state        : FSM state for debug
//   CNT_W is limited to 32 by sat_inc().
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_checker_if.slave      link,
    output logic                 failure,
    output logic                 timeout,
    output logic [CNT_W-1:0]     word_count,
    output logic [CNT_W-1:0]     error_count,
    output logic [1:0]           state
);

    logic [DATA_W-1:0] expected;
    logic              wd_expired;
    logic [CNT_W-1:0]  word_count_inc;
    logic [CNT_W-1:0]  error_count_inc;

    assign word_count_inc  = CNT_W'(sat_inc(32'(word_count), CNT_W));
    assign error_count_inc = CNT_W'(sat_inc(32'(error_count), CNT_W));

`ifdef STREAM_CHECKER_TIMEOUT_EN
    gap_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_gap_watchdog (
        .clk     (clk),
        .rst     (rst),
        .arm     ((state == ST_TRACK) || (state == ST_FAILED)),
        .kick    (link.en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (wd_expired) begin
            timeout <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WAIT_FIRST;
            failure     <= 1'b0;
            word_count  <= '0;
            error_count <= '0;
            expected    <= '0;
        end else begin
            // A stall only flags failure; the FSM keeps tracking the sequence.
            if (wd_expired) begin
                failure <= 1'b1;
            end
            case (state)
                ST_WAIT_FIRST: begin
                    if (link.en) begin
                        expected   <= link.data + DATA_W'(1);
                        word_count <= word_count_inc;
                        state      <= ST_TRACK;
                    end
                end
                ST_TRACK, ST_FAILED: begin
                    if (link.en) begin
                        word_count <= word_count_inc;
                        if (link.data == expected) begin
                            expected <= expected + DATA_W'(1);
                        end else begin
                            // Resynchronise on the offending word so one
                            // glitch costs one error, not a run of them.
                            expected    <= link.data + DATA_W'(1);
                            error_count <= error_count_inc;
                            failure     <= 1'b1;
                            state       <= ST_FAILED;
                        end
                    end
                end
                default: state <= ST_WAIT_FIRST;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker
//   Drives two checker instances from one link: dut0 (CNT_W=16, TIMEOUT=16)
//   and dut1 (CNT_W=4, TIMEOUT=8, exercises saturation). A behavioural model
//   kept per instance predicts every output after every clock.
module tb_stream_checker;

`ifdef STREAM_CHECKER_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_checker_if #(.DATA_W(4)) bus ();

    logic        fail0, to0, fail1, to1;
    logic [15:0] wc0, ec0;
    logic [3:0]  wc1, ec1;
    logic [1:0]  st0, st1;

    stream_checker #(.DATA_W(4), .CNT_W(16), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .link(bus.slave),
        .failure(fail0), .timeout(to0), .word_count(wc0), .error_count(ec0), .state(st0)
    );

    stream_checker #(.DATA_W(4), .CNT_W(4), .TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .link(bus.slave),
        .failure(fail1), .timeout(to1), .word_count(wc1), .error_count(ec1), .state(st1)
    );

    // Reference model: "have we seen a word", "have we seen a break",
    // next expected value, plain integer counts and idle run length.
    int cmax [2] = '{65535, 15};
    int tout [2] = '{16, 8};
    bit m_started [2];
    bit m_bad     [2];
    bit m_to      [2];
    int m_exp     [2];
    int m_wc      [2];
    int m_ec      [2];
    int m_idle    [2];

    int passes = 0;
    int total  = 0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_step(input bit r, input bit e, input int d);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_started[i] = 0; m_bad[i] = 0; m_to[i] = 0;
                m_exp[i] = 0; m_wc[i] = 0; m_ec[i] = 0; m_idle[i] = 0;
            end else if (e) begin
                m_idle[i] = 0;
                m_wc[i] = sat(m_wc[i] + 1, cmax[i]);
                if (m_started[i] && d != m_exp[i]) begin
                    m_ec[i]  = sat(m_ec[i] + 1, cmax[i]);
                    m_bad[i] = 1;
                end
                m_started[i] = 1;
                m_exp[i] = (d + 1) % 16;
            end else if (WD && m_started[i]) begin
                if (m_idle[i] < tout[i]) m_idle[i]++;
                if (m_idle[i] == tout[i]) m_to[i] = 1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_state(input int i);
        if (!m_started[i]) return 0;
        return m_bad[i] ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/d0_state"},   32'(st0),   exp_state(0));
        chk({tag, "/d0_failure"}, 32'(fail0), 32'(m_bad[0] | m_to[0]));
        chk({tag, "/d0_timeout"}, 32'(to0),   32'(m_to[0]));
        chk({tag, "/d0_wc"},      32'(wc0),   32'(m_wc[0]));
        chk({tag, "/d0_ec"},      32'(ec0),   32'(m_ec[0]));
        chk({tag, "/d1_state"},   32'(st1),   exp_state(1));
        chk({tag, "/d1_failure"}, 32'(fail1), 32'(m_bad[1] | m_to[1]));
        chk({tag, "/d1_timeout"}, 32'(to1),   32'(m_to[1]));
        chk({tag, "/d1_wc"},      32'(wc1),   32'(m_wc[1]));
        chk({tag, "/d1_ec"},      32'(ec1),   32'(m_ec[1]));
    endtask

    task automatic step(input bit r, input bit e, input int d, input string tag);
        rst      = r;
        bus.en   = e;
        bus.data = 4'(d);
        @(posedge clk);
        model_step(r, e, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.en   = 1'b0;
        bus.data = 4'd0;

        // reset values
        step(1, 0, 0, "rst");
        step(1, 1, 7, "rst_beat");
        chk("rst_state", 32'(st0), 0);
        chk("rst_wc", 32'(wc0), 0);
        chk("rst_fail", 32'(fail0), 0);

        // 3,4,5,6 in sequence
        step(0, 1, 3, "seq"); step(0, 1, 4, "seq");
        step(0, 1, 5, "seq"); step(0, 1, 6, "seq");
        chk("seq_state", 32'(st0), 1);
        chk("seq_wc", 32'(wc0), 4);
        chk("seq_ec", 32'(ec0), 0);
        chk("seq_fail", 32'(fail0), 0);

        // wrap 14,15,0,1
        step(1, 0, 0, "rst");
        step(0, 1, 14, "wrap"); step(0, 1, 15, "wrap");
        step(0, 1, 0, "wrap");  step(0, 1, 1, "wrap");
        chk("wrap_ec", 32'(ec0), 0);
        chk("wrap_wc", 32'(wc0), 4);
        chk("wrap_state", 32'(st0), 1);

        // break 2,3,7,8
        step(1, 0, 0, "rst");
        step(0, 1, 2, "brk"); step(0, 1, 3, "brk");
        chk("brk_pre_fail", 32'(fail0), 0);
        step(0, 1, 7, "brk");
        chk("brk_fail", 32'(fail0), 1);
        chk("brk_ec", 32'(ec0), 1);
        chk("brk_state", 32'(st0), 2);
        step(0, 1, 8, "brk");
        chk("brk_after_ec", 32'(ec0), 1);
        chk("brk_after_wc", 32'(wc0), 4);

        // watchdog: beat 5 then 16 idle cycles
        step(1, 0, 0, "rst");
        step(0, 1, 5, "wd");
        for (int i = 0; i < 15; i++) step(0, 0, 0, "wd_idle");
        chk("wd_early_timeout", 32'(to0), 0);
        step(0, 0, 0, "wd_idle");
        chk("wd_timeout", 32'(to0), 32'(WD));
        chk("wd_failure", 32'(fail0), 32'(WD));
        chk("wd_state", 32'(st0), 1);

        // mid-stream reset while failing, then fresh start
        step(0, 1, 9, "mrst_bad");
        chk("mrst_pre_fail", 32'(fail0), 1);
        step(1, 1, 3, "mrst");
        chk("mrst_state", 32'(st0), 0);
        chk("mrst_fail", 32'(fail0), 0);
        chk("mrst_wc", 32'(wc0), 0);
        step(0, 1, 9, "mrst_first");
        chk("mrst_first_ec", 32'(ec0), 0);
        chk("mrst_first_state", 32'(st0), 1);

        // saturation: 20 alternating mismatching beats
        step(1, 0, 0, "rst");
        for (int i = 0; i < 20; i++) step(0, 1, (i % 2) ? 8 : 0, "sat");
        chk("sat_d1_ec", 32'(ec1), 15);
        chk("sat_d1_wc", 32'(wc1), 15);
        chk("sat_d0_ec", 32'(ec0), 19);
        chk("sat_d0_wc", 32'(wc0), 20);

        // randomized traffic against the model
        step(1, 0, 0, "rst");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                step(1, $urandom_range(0, 1), $urandom_range(0, 15), "rnd_rst");
            end else if ($urandom_range(0, 15) == 0) begin
                int len;
                len = $urandom_range(5, 20);
                for (int k = 0; k < len; k++) step(0, 0, $urandom_range(0, 15), "rnd_idle");
            end else begin
                bit e;
                int d;
                e = ($urandom_range(0, 3) != 0);
                d = ($urandom_range(0, 2) != 0) ? m_exp[0] : int'($urandom_range(0, 15));
                step(0, e, d, "rnd");
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
